// File: rtl/adder8_seq_pkg.sv
// adder8_seq shared types.
// Opcodes, FSM states and the supported width limit.
package adder8_seq_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_ADC = 2'b10,
      OP_SBB = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_e;

   localparam int MAX_WORDS = 16;

endpackage

// File: rtl/adder8.sv
// adder8: 8-bit combinational adder with carry in/out.
// Shared byte-slice datapath for multi-precision arithmetic.
module adder8 (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic       cin_i,
   output logic [7:0] sum_o,
   output logic       cout_o
);

   assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {8'b0, cin_i};

endmodule

// File: rtl/adder8_seq.sv
// adder8_seq: WORDS-byte add/sub using one 8-bit adder,
// LSB-first, carry chained through carry_q.
module adder8_seq
   import adder8_seq_pkg::*;
#(
   parameter int WORDS = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         in_op,
   input  logic [8*WORDS-1:0] in_a,
   input  logic [8*WORDS-1:0] in_b,
   input  logic               in_cin,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8*WORDS-1:0] out_sum,
   output logic               out_cout,
   output logic               out_ovf,
   output logic               busy
);

   localparam int W  = 8 * WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   state_e          state_q, state_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            carry_q, carry_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            cout_q, cout_d;
   logic            ovf_q, ovf_d;

   logic [7:0]      add_a, add_b, add_s;
   logic            add_co;

   assign add_a = a_q[8*idx_q +: 8];
   assign add_b = b_q[8*idx_q +: 8];

   adder8 u_adder8 (
      .a_i    (add_a),
      .b_i    (add_b),
      .cin_i  (carry_q),
      .sum_o  (add_s),
      .cout_o (add_co)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               idx_d   = '0;
               state_d = S_RUN;
               unique case (op_e'(in_op))
                  OP_ADD: begin
                     b_d     = in_b;
                     carry_d = 1'b0;
                  end
                  OP_SUB: begin
                     b_d     = ~in_b;
                     carry_d = 1'b1;
                  end
                  OP_ADC: begin
                     b_d     = in_b;
                     carry_d = in_cin;
                  end
                  OP_SBB: begin
                     b_d     = ~in_b;
                     carry_d = in_cin;
                  end
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            sum_d[8*idx_q +: 8] = add_s;
            carry_d             = add_co;
            if (idx_q == LAST) begin
               // Signed overflow: like-signed operands, sum sign differs.
               cout_d  = add_co;
               ovf_d   = (a_q[W-1] == b_q[W-1])
                         && (add_s[7] != a_q[W-1]);
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign out_sum   = sum_q;
   assign out_cout  = cout_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_adder8_seq.sv
// Directed bench for adder8_seq at WORDS=4 and WORDS=1.
// Hand-computed vectors, latency, backpressure and reset checks.
module tb_adder8_seq;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        iv4, ir4, ov4, or4, co4, of4, busy4, cin4;
   logic [1:0]  op4;
   logic [31:0] a4, b4, s4;

   logic        iv1, ir1, ov1, or1, co1, of1, busy1, cin1;
   logic [1:0]  op1;
   logic [7:0]  a1, b1, s1;

   adder8_seq #(.WORDS(4)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv4),
      .in_ready  (ir4),
      .in_op     (op4),
      .in_a      (a4),
      .in_b      (b4),
      .in_cin    (cin4),
      .out_valid (ov4),
      .out_ready (or4),
      .out_sum   (s4),
      .out_cout  (co4),
      .out_ovf   (of4),
      .busy      (busy4)
   );

   adder8_seq #(.WORDS(1)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv1),
      .in_ready  (ir1),
      .in_op     (op1),
      .in_a      (a1),
      .in_b      (b1),
      .in_cin    (cin1),
      .out_valid (ov1),
      .out_ready (or1),
      .out_sum   (s1),
      .out_cout  (co1),
      .out_ovf   (of1),
      .busy      (busy1)
   );

   // Issues one request on dut4 and drains its result.
   task automatic issue4(
      input  logic [1:0]  op,
      input  logic [31:0] a,
      input  logic [31:0] b,
      input  logic        cin,
      output int          lat,
      output logic [31:0] s,
      output logic        co,
      output logic        of
   );
      iv4 = 1'b1; op4 = op; a4 = a; b4 = b; cin4 = cin;
      @(posedge clk); #1;
      iv4 = 1'b0;
      lat = 0;
      while (!ov4 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      s = s4; co = co4; of = of4;
      or4 = 1'b1;
      @(posedge clk); #1;
      or4 = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({ir4, ov4, co4, of4, busy4} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctl4 got %b want 10000",
                  {ir4, ov4, co4, of4, busy4});
      end
      checks++;
      if (s4 !== 32'h0) begin
         errors++;
         $display("FAIL reset_sum4 got %h want 0", s4);
      end
      checks++;
      if ({ir1, ov1, co1, of1, busy1} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctl1 got %b want 10000",
                  {ir1, ov1, co1, of1, busy1});
      end
   endtask

   task automatic test_add();
      int lat; logic [31:0] s; logic co, of;
      issue4(2'b00, 32'h000000FF, 32'h1, 1'b0, lat, s, co, of);
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("FAIL add_latency got %0d want 4", lat);
      end
      checks++;
      if ({s, co, of} !== {32'h00000100, 2'b00}) begin
         errors++;
         $display("FAIL add_ff_1 got %h/%b%b want 00000100/00", s, co, of);
      end
      issue4(2'b00, 32'hFFFFFFFF, 32'h1, 1'b0, lat, s, co, of);
      checks++;
      if ({s, co, of} !== {32'h00000000, 2'b10}) begin
         errors++;
         $display("FAIL add_wrap got %h/%b%b want 00000000/10", s, co, of);
      end
      issue4(2'b00, 32'h7FFFFFFF, 32'h1, 1'b0, lat, s, co, of);
      checks++;
      if ({s, co, of} !== {32'h80000000, 2'b01}) begin
         errors++;
         $display("FAIL add_ovf got %h/%b%b want 80000000/01", s, co, of);
      end
      issue4(2'b10, 32'h12345678, 32'h11111111, 1'b1, lat, s, co, of);
      checks++;
      if ({s, co, of} !== {32'h2345678A, 2'b00}) begin
         errors++;
         $display("FAIL adc got %h/%b%b want 2345678A/00", s, co, of);
      end
   endtask

   task automatic test_sub();
      int lat; logic [31:0] s; logic co, of;
      issue4(2'b01, 32'h0, 32'h1, 1'b1, lat, s, co, of);
      checks++;
      if ({s, co, of} !== {32'hFFFFFFFF, 2'b00}) begin
         errors++;
         $display("FAIL sub_borrow got %h/%b%b want FFFFFFFF/00", s, co, of);
      end
      issue4(2'b01, 32'h80000000, 32'h1, 1'b0, lat, s, co, of);
      checks++;
      if ({s, co, of} !== {32'h7FFFFFFF, 2'b11}) begin
         errors++;
         $display("FAIL sub_ovf got %h/%b%b want 7FFFFFFF/11", s, co, of);
      end
      issue4(2'b11, 32'h5, 32'h3, 1'b0, lat, s, co, of);
      checks++;
      if (s !== 32'h00000001) begin
         errors++;
         $display("FAIL sbb got %h want 00000001", s);
      end
   endtask

   task automatic test_backpressure();
      int lat;
      iv4 = 1'b1; op4 = 2'b00; a4 = 32'h10; b4 = 32'h20; cin4 = 1'b0;
      @(posedge clk); #1;
      a4 = 32'h1; b4 = 32'h2;
      lat = 0;
      while (!ov4 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      for (int c = 0; c < 6; c++) begin
         checks++;
         if ({ov4, ir4, busy4, s4, co4, of4} !==
             {3'b101, 32'h30, 2'b00}) begin
            errors++;
            $display("FAIL hold_c%0d got %b%b%b/%h/%b%b want 101/30/00",
                     c, ov4, ir4, busy4, s4, co4, of4);
         end
         @(posedge clk); #1;
      end
      or4 = 1'b1;
      @(posedge clk); #1;
      or4 = 1'b0;
      checks++;
      if ({ov4, ir4, busy4} !== 3'b010) begin
         errors++;
         $display("FAIL idle_gap got %b want 010", {ov4, ir4, busy4});
      end
      @(posedge clk); #1;
      iv4 = 1'b0;
      checks++;
      if ({ir4, busy4} !== 2'b01) begin
         errors++;
         $display("FAIL reaccept got %b want 01", {ir4, busy4});
      end
      lat = 0;
      while (!ov4 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (s4 !== 32'h3) begin
         errors++;
         $display("FAIL second_res got %h want 00000003", s4);
      end
      or4 = 1'b1;
      @(posedge clk); #1;
      or4 = 1'b0;
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] s; logic co, of; logic seen;
      iv4 = 1'b1; op4 = 2'b00;
      a4 = 32'h01010101; b4 = 32'h02020202; cin4 = 1'b0;
      @(posedge clk); #1;
      iv4 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ir4, ov4, co4, of4, busy4} !== 5'b10000) begin
         errors++;
         $display("FAIL midrst_ctl got %b want 10000",
                  {ir4, ov4, co4, of4, busy4});
      end
      checks++;
      if (s4 !== 32'h0) begin
         errors++;
         $display("FAIL midrst_sum got %h want 0", s4);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         seen |= ov4;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL midrst_valid got %b want 0", seen);
      end
      issue4(2'b00, 32'h1, 32'h1, 1'b0, lat, s, co, of);
      checks++;
      if (s !== 32'h2) begin
         errors++;
         $display("FAIL post_rst got %h want 00000002", s);
      end
   endtask

   task automatic test_words1();
      int lat; int first; int second;
      iv1 = 1'b1; op1 = 2'b10; a1 = 8'hFF; b1 = 8'h00; cin1 = 1'b1;
      @(posedge clk); #1;
      iv1 = 1'b0;
      lat = 0;
      while (!ov1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat !== 1) begin
         errors++;
         $display("FAIL w1_latency got %0d want 1", lat);
      end
      checks++;
      if ({s1, co1, of1} !== {8'h00, 2'b10}) begin
         errors++;
         $display("FAIL w1_adc got %h/%b%b want 00/10", s1, co1, of1);
      end
      or1 = 1'b1;
      @(posedge clk); #1;
      op1 = 2'b00; a1 = 8'h1; b1 = 8'h1;
      iv1 = 1'b1;
      first = -1; second = -1;
      for (int c = 0; c < 12; c++) begin
         if (ir1) begin
            if (first < 0) first = c;
            else if (second < 0) second = c;
         end
         @(posedge clk); #1;
      end
      iv1 = 1'b0; or1 = 1'b0;
      checks++;
      if (second - first !== 3 || first < 0 || second < 0) begin
         errors++;
         $display("FAIL w1_interval got %0d want 3", second - first);
      end
   endtask

   initial begin
      iv4 = 1'b0; or4 = 1'b0; op4 = 2'b00;
      a4 = '0; b4 = '0; cin4 = 1'b0;
      iv1 = 1'b0; or1 = 1'b0; op1 = 2'b00;
      a1 = '0; b1 = '0; cin1 = 1'b0;
      #1;
      test_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_add();
      test_sub();
      test_backpressure();
      test_reset_mid();
      test_words1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
